// File: rtl/rom_weight_loader.sv
// Copies NUM_UNITS consecutive words from an external synchronous ROM into the unit
// data registers, then pulses net_start_o. Optional checksum port: ROM_WEIGHT_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module rom_weight_loader #(
  parameter int DATA_W    = 32,
  parameter int NUM_UNITS = 4,
  parameter int UNIT_AW   = 2,
  parameter int ROM_AW    = 10,
  parameter int ROM_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [ROM_AW-1:0]  load_base_i,
  output logic               rom_en_o,
  output logic [ROM_AW-1:0]  rom_addr_o,
  input  logic [DATA_W-1:0]  rom_data_i,
  output logic               wr_en_o,
  output logic [UNIT_AW-1:0] wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               net_start_o,
  output logic               busy_o
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  checksum_o
`endif
);

  localparam int LAT_W = $clog2(ROM_LAT + 1);
  localparam logic [UNIT_AW-1:0] LAST_UNIT = UNIT_AW'(NUM_UNITS - 1);
  localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(ROM_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [UNIT_AW-1:0] unit_q, unit_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               rom_en_q, rom_en_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [UNIT_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               net_start_q, net_start_d;
  logic               busy_q, busy_d;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  checksum_q, checksum_d;
`endif

  // Strobes are derived from the next state so each one is a flop aligned with its state.
  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    lat_d      = lat_q;
    rom_addr_d = rom_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rom_addr_d = load_base_i;
          unit_d     = {UNIT_AW{1'b0}};
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
          checksum_d = {DATA_W{1'b0}};
`endif
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          wr_data_d = rom_data_i;
          wr_addr_d = unit_q;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
          checksum_d = checksum_q + rom_data_i;
`endif
          state_d   = WRITE;
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        if (unit_q == LAST_UNIT) begin
          state_d = FINISH;
        end else begin
          unit_d     = unit_q + UNIT_AW'(1);
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = ISSUE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rom_en_d    = (state_d == ISSUE);
    wr_en_d     = (state_d == WRITE);
    net_start_d = (state_d == FINISH);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      unit_q      <= {UNIT_AW{1'b0}};
      lat_q       <= {LAT_W{1'b0}};
      rom_en_q    <= 1'b0;
      rom_addr_q  <= {ROM_AW{1'b0}};
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {UNIT_AW{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      net_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
      checksum_q  <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      unit_q      <= unit_d;
      lat_q       <= lat_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      net_start_q <= net_start_d;
      busy_q      <= busy_d;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign rom_en_o    = rom_en_q;
  assign rom_addr_o  = rom_addr_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign net_start_o = net_start_q;
  assign busy_o      = busy_q;
`ifdef ROM_WEIGHT_LOADER_CHECKSUM_EN
  assign checksum_o  = checksum_q;
`endif

endmodule
